// File: rtl/irq_timer_pkg.sv
// Shared constants for the interrupt timer: bus register map, TCON bit positions
// and the interrupt request FSM encoding.
package irq_timer_pkg;

    localparam logic [31:0] ADDR_TH   = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL   = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON = 32'h4000_0008;
    localparam logic [31:0] ADDR_ICNT = 32'h4000_000C;

    localparam int TCON_TEN = 0;
    localparam int TCON_TIE = 1;
    localparam int TCON_TIF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/timer_core.sv
// Free-running up counter with reload register; ovf flags the cycle in which
// the counter wraps from all-ones back to the reload value.
module timer_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        th_we,
    input  logic        tl_we,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic        ovf
);

    assign ovf = en && (tl == 32'hFFFF_FFFF);

    // A software write to the counter takes priority over the reload on wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th <= '0;
            tl <= '0;
        end else begin
            if (th_we) begin
                th <= wdata;
            end
            if (tl_we) begin
                tl <= wdata;
            end else if (ovf) begin
                tl <= th;
            end else if (en) begin
                tl <= tl + 32'd1;
            end
        end
    end

endmodule

// File: rtl/irq_timer_ctrl.sv
// Memory-mapped timer with interrupt request logic: bus decode, TCON, taken-interrupt
// counter and the IDLE/PENDING/SERVICE request FSM around a timer_core.
module irq_timer_ctrl
    import irq_timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWr,
    input  logic        MemRd,
    output logic [31:0] ReadData,
    input  logic        PCSupervisor,
    input  logic        IrqTaken,
    output logic        IRQ
);

    logic [31:0] th;
    logic [31:0] tl;
    logic [31:0] icnt;
    logic        ten;
    logic        tie;
    logic        tif;
    logic        ovf;
    logic        th_we;
    logic        tl_we;
    logic        tcon_we;
    irq_state_t  state;

    assign th_we   = MemWr && (Addr == ADDR_TH);
    assign tl_we   = MemWr && (Addr == ADDR_TL);
    assign tcon_we = MemWr && (Addr == ADDR_TCON);

    timer_core u_core (
        .clk   (clk),
        .reset (reset),
        .en    (ten),
        .th_we (th_we),
        .tl_we (tl_we),
        .wdata (WriteData),
        .th    (th),
        .tl    (tl),
        .ovf   (ovf)
    );

    // An enabled overflow sets TIF even if software writes TCON in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ten <= 1'b0;
            tie <= 1'b0;
            tif <= 1'b0;
        end else if (tcon_we) begin
            ten <= WriteData[TCON_TEN];
            tie <= WriteData[TCON_TIE];
            tif <= WriteData[TCON_TIF] | (ovf & tie);
        end else if (ovf && tie) begin
            tif <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            IRQ   <= 1'b0;
            icnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tif && tie && !PCSupervisor) begin
                        state <= PENDING;
                        IRQ   <= 1'b1;
                    end
                end
                PENDING: begin
                    if (IrqTaken) begin
                        state <= SERVICE;
                        IRQ   <= 1'b0;
                        icnt  <= sat_inc(icnt);
                    end else if (!tif || !tie) begin
                        state <= IDLE;
                        IRQ   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (!PCSupervisor) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    IRQ   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ReadData = '0;
        if (MemRd) begin
            case (Addr)
                ADDR_TH:   ReadData = th;
                ADDR_TL:   ReadData = tl;
                ADDR_TCON: ReadData = {29'd0, tif, tie, ten};
                ADDR_ICNT: ReadData = icnt;
                default:   ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Self-checking bench for irq_timer_ctrl: register table, directed corner cases
// and randomized bus traffic against a behavioural model.
module tb_irq_timer_ctrl;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_ICNT = 32'h4000_000C;
    localparam logic [31:0] A_BAD  = 32'h4000_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemWr;
    logic        MemRd;
    logic [31:0] ReadData;
    logic        PCSupervisor;
    logic        IrqTaken;
    logic        IRQ;

    int errors = 0;
    int checks = 0;
    logic [31:0] sampledRd;
    logic [31:0] modelRd;

    logic [31:0] mTh, mTl, mIcnt;
    bit          mTen, mTie, mTif, mReq, mHandler;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pcs;
        logic        taken;
        logic [31:0] expRd;
        logic        expIrq;
    } vec_t;

    vec_t vecs[18];

    irq_timer_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .Addr         (Addr),
        .WriteData    (WriteData),
        .MemWr        (MemWr),
        .MemRd        (MemRd),
        .ReadData     (ReadData),
        .PCSupervisor (PCSupervisor),
        .IrqTaken     (IrqTaken),
        .IRQ          (IRQ)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic rd, input logic [31:0] a);
        if (!rd) return 32'h0;
        if (a == A_TH)   return mTh;
        if (a == A_TL)   return mTl;
        if (a == A_TCON) return {29'd0, mTif, mTie, mTen};
        if (a == A_ICNT) return mIcnt;
        return 32'h0;
    endfunction

    task automatic modelReset();
        mTh = 0; mTl = 0; mIcnt = 0;
        mTen = 0; mTie = 0; mTif = 0; mReq = 0; mHandler = 0;
    endtask

    // One bus cycle: drive at the falling edge, sample ReadData before the rising
    // edge, advance the model across the edge, then leave outputs settled.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] a,
                                 input logic [31:0] wd, input logic pcs, input logic taken);
        bit ovf, setTif;
        logic [31:0] nTh, nTl, nIcnt;
        bit nTen, nTie, nTif, nReq, nHandler;
        @(negedge clk);
        MemWr = wr; MemRd = rd; Addr = a; WriteData = wd;
        PCSupervisor = pcs; IrqTaken = taken;
        #1;
        sampledRd = ReadData;
        modelRd = modelRead(rd, a);
        ovf = mTen && (mTl == 32'hFFFF_FFFF);
        setTif = ovf && mTie;
        nTh = (wr && a == A_TH) ? wd : mTh;
        nTl = (wr && a == A_TL) ? wd : (ovf ? mTh : (mTen ? mTl + 32'd1 : mTl));
        nTen = mTen; nTie = mTie; nTif = mTif;
        if (wr && a == A_TCON) begin
            nTen = wd[0]; nTie = wd[1]; nTif = wd[2];
        end
        nTif = nTif | setTif;
        nReq = mReq; nHandler = mHandler; nIcnt = mIcnt;
        if (mHandler) begin
            if (!pcs) nHandler = 0;
        end else if (mReq) begin
            if (taken) begin
                nReq = 0; nHandler = 1;
                if (mIcnt != 32'hFFFF_FFFF) nIcnt = mIcnt + 32'd1;
            end else if (!(mTif && mTie)) begin
                nReq = 0;
            end
        end else if (mTif && mTie && !pcs) begin
            nReq = 1;
        end
        @(posedge clk);
        mTh = nTh; mTl = nTl; mIcnt = nIcnt;
        mTen = nTen; mTie = nTie; mTif = nTif; mReq = nReq; mHandler = nHandler;
        #1;
    endtask

    task automatic idleCycle(input logic pcs, input logic taken);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, pcs, taken);
    endtask

    task automatic resetDut();
        MemWr = 0; MemRd = 0; Addr = 0; WriteData = 0;
        PCSupervisor = 0; IrqTaken = 0;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] addrs[5];
        logic [31:0] wd, a;
        logic wr, rd;
        int op;

        addrs[0] = A_TH; addrs[1] = A_TL; addrs[2] = A_TCON; addrs[3] = A_ICNT; addrs[4] = A_BAD;

        vecs[0]  = '{1'b1, 1'b0, A_TH,   32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 1'b1, A_TH,   32'h0,         1'b0, 1'b0, 32'h1234_5678, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, A_TL,   32'hAAAA_5555, 1'b0, 1'b0, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 1'b1, A_TL,   32'h0,         1'b0, 1'b0, 32'hAAAA_5555, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, A_ICNT, 32'h0000_FFFF, 1'b0, 1'b0, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, 1'b1, A_ICNT, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        vecs[6]  = '{1'b1, 1'b0, A_BAD,  32'h7,         1'b0, 1'b0, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 1'b1, A_TCON, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 1'b1, A_BAD,  32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        vecs[9]  = '{1'b1, 1'b0, A_TCON, 32'h6,         1'b1, 1'b0, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 1'b1, A_TCON, 32'h0,         1'b1, 1'b0, 32'h6,         1'b0};
        vecs[11] = '{1'b0, 1'b1, A_TCON, 32'h0,         1'b0, 1'b0, 32'h6,         1'b1};
        vecs[12] = '{1'b0, 1'b0, A_TCON, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1};
        vecs[13] = '{1'b1, 1'b0, A_TCON, 32'h2,         1'b0, 1'b0, 32'h0,         1'b1};
        vecs[14] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        vecs[15] = '{1'b0, 1'b1, A_TCON, 32'h0,         1'b0, 1'b0, 32'h2,         1'b0};
        vecs[16] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 32'h0,         1'b0};
        vecs[17] = '{1'b0, 1'b1, A_ICNT, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};

        reset = 1'b0;
        resetDut();
        #1;
        checkOutput("reset_irq", {31'd0, IRQ}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].pcs, vecs[i].taken);
            checkOutput($sformatf("vec%0d_rdata", i), sampledRd, vecs[i].expRd);
            checkOutput($sformatf("vec%0d_irq", i), {31'd0, IRQ}, {31'd0, vecs[i].expIrq});
        end

        // Overflow into TIF, then a full take / service / return round trip.
        resetDut();
        applyStimulus(1, 0, A_TH, 32'hFFFF_FFFC, 0, 0);
        applyStimulus(1, 0, A_TL, 32'hFFFF_FFFE, 0, 0);
        applyStimulus(1, 0, A_TCON, 32'h3, 0, 0);
        applyStimulus(0, 1, A_TL, 0, 0, 0);
        checkOutput("s1_tl_counting", sampledRd, 32'hFFFF_FFFE);
        checkOutput("s1_irq_before_ovf", {31'd0, IRQ}, 32'd0);
        applyStimulus(0, 1, A_TCON, 0, 0, 0);
        checkOutput("s1_tcon_pre", sampledRd, 32'h3);
        checkOutput("s1_irq_same_as_tif", {31'd0, IRQ}, 32'd0);
        applyStimulus(0, 1, A_TL, 0, 0, 0);
        checkOutput("s1_tl_reload", sampledRd, 32'hFFFF_FFFC);
        checkOutput("s1_irq_after_tif", {31'd0, IRQ}, 32'd1);
        applyStimulus(0, 1, A_TCON, 0, 0, 0);
        checkOutput("s1_tif_set", sampledRd, 32'h7);
        checkOutput("s1_irq_held", {31'd0, IRQ}, 32'd1);
        idleCycle(1, 1);
        checkOutput("s2_irq_fall_on_take", {31'd0, IRQ}, 32'd0);
        applyStimulus(0, 1, A_ICNT, 0, 1, 1);
        checkOutput("s2_icnt_one", sampledRd, 32'd1);
        checkOutput("s2_irq_service_ovf", {31'd0, IRQ}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            idleCycle(1, 1);
            checkOutput("s2_irq_in_service", {31'd0, IRQ}, 32'd0);
        end
        idleCycle(0, 0);
        checkOutput("s2_irq_idle_gap", {31'd0, IRQ}, 32'd0);
        idleCycle(0, 0);
        checkOutput("s2_irq_again", {31'd0, IRQ}, 32'd1);
        applyStimulus(0, 1, A_ICNT, 0, 0, 0);
        checkOutput("s2_icnt_take_ignored", sampledRd, 32'd1);

        // TCON write colliding with a TIF-setting overflow.
        resetDut();
        applyStimulus(1, 0, A_TH, 32'h100, 0, 0);
        applyStimulus(1, 0, A_TL, 32'hFFFF_FFFF, 0, 0);
        applyStimulus(1, 0, A_TCON, 32'h3, 0, 0);
        applyStimulus(1, 0, A_TCON, 32'h3, 0, 0);
        applyStimulus(0, 1, A_TCON, 0, 0, 0);
        checkOutput("s3_tcon_wr_ovf", sampledRd, 32'h7);
        applyStimulus(0, 1, A_TL, 0, 0, 0);
        checkOutput("s3_tl_from_th", sampledRd, 32'h101);

        // TL write colliding with an overflow.
        resetDut();
        applyStimulus(1, 0, A_TH, 32'h500, 0, 0);
        applyStimulus(1, 0, A_TL, 32'hFFFF_FFFF, 0, 0);
        applyStimulus(1, 0, A_TCON, 32'h1, 0, 0);
        applyStimulus(1, 0, A_TL, 32'h10, 0, 0);
        applyStimulus(0, 1, A_TL, 0, 0, 0);
        checkOutput("s4_tl_write_wins", sampledRd, 32'h10);

        // Overflow with interrupts disabled.
        resetDut();
        applyStimulus(1, 0, A_TL, 32'hFFFF_FFFD, 0, 0);
        applyStimulus(1, 0, A_TCON, 32'h1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            idleCycle(0, 0);
            checkOutput("s5_no_irq_tie0", {31'd0, IRQ}, 32'd0);
        end
        applyStimulus(0, 1, A_TCON, 0, 0, 0);
        checkOutput("s5_tif_clear", sampledRd, 32'h1);
        applyStimulus(0, 1, A_BAD, 0, 0, 0);
        checkOutput("s5_unmapped_read", sampledRd, 32'h0);

        // Reset pulled in the middle of a pending request.
        resetDut();
        applyStimulus(1, 0, A_TH, 32'hDEAD_BEEF, 0, 0);
        applyStimulus(1, 0, A_TCON, 32'h6, 0, 0);
        idleCycle(0, 0);
        checkOutput("s6_pending_irq", {31'd0, IRQ}, 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("s6_async_irq_drop", {31'd0, IRQ}, 32'd0);
        MemRd = 1'b1; Addr = A_TH;
        #1;
        checkOutput("s6_rd_th_in_reset", ReadData, 32'h0);
        MemRd = 1'b0; Addr = A_TCON;
        #1;
        checkOutput("s6_rd_idle_in_reset", ReadData, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("s6_irq_held_low", {31'd0, IRQ}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, addrs[k], 0, 0, 0);
            checkOutput($sformatf("s6_reg%0d_zero", k), sampledRd, 32'h0);
            checkOutput("s6_irq_after_release", {31'd0, IRQ}, 32'd0);
        end

        // Randomized traffic checked against the model.
        resetDut();
        for (int i = 0; i < 400; i++) begin
            wr = 0; rd = 0; a = 0; wd = $urandom;
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1: begin
                    wr = 1; a = A_TL;
                    if ($urandom_range(0, 3) != 0) wd = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                end
                2: begin
                    wr = 1; a = A_TH;
                    if ($urandom_range(0, 1) != 0) wd = 32'hFFFF_FFF8 + $urandom_range(0, 7);
                end
                3: begin
                    wr = 1; a = A_TCON;
                    wd = ($urandom & 32'hFFFF_FFF8) | $urandom_range(0, 7);
                end
                4: begin wr = 1; a = A_ICNT; end
                5: begin wr = 1; a = A_BAD; end
                6, 7, 8: begin rd = 1; a = addrs[$urandom_range(0, 4)]; end
                default: ;
            endcase
            applyStimulus(wr, rd, a, wd, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            checkOutput("rand_rdata", sampledRd, modelRd);
            checkOutput("rand_irq", {31'd0, IRQ}, {31'd0, mReq});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_timer_ctrl.md
IRQ_TIMER_CTRL -- requirements
Module: irq_timer_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and reset.
REQ-002 The block SHALL provide these ports:
  - clk  in  1  system clock; all state changes on the rising edge
  - reset  in  1  asynchronous, active-low reset
  - Addr  in  32  data-memory bus address
  - WriteData  in  32  bus write data
  - MemWr  in  1  bus write strobe
  - MemRd  in  1  bus read strobe
  - ReadData  out  32  bus read data
  - PCSupervisor  in  1  CPU in kernel mode (PC[31])
  - IrqTaken  in  1  CPU is taking the interrupt vector this cycle
  - IRQ  out  1  interrupt request to the instruction decoder
REQ-003 The block SHALL decode these word addresses (decimal/hex as shown):
  - 0x40000000 TH: reload value, R/W
  - 0x40000004 TL: counter, R/W
  - 0x40000008 TCON[2:0]: R/W; bit0 TEN, bit1 TIE, bit2 TIF
  - 0x4000000C ICNT: taken-interrupt count, read-only

Function
REQ-004 ReadData SHALL be combinational: the selected register (zero-extended) when MemRd=1 and Addr matches a decoded address, otherwise 32'h0.
REQ-005 When MemWr=1 and Addr matches a register, the write SHALL take effect on that clock edge; unmatched addresses and writes to ICNT SHALL be ignored.
REQ-006 While TEN=1, TL SHALL increment by 1 each cycle, with 32-bit arithmetic.
REQ-007 When TEN=1 and TL=32'hFFFFFFFF, the next value of TL SHALL be TH, and a one-cycle overflow event SHALL occur.
REQ-008 An overflow event with TIE=1 SHALL set TIF; with TIE=0, TIF SHALL stay unchanged.
REQ-009 If a software write to TL and an overflow happen in the same cycle, the software value SHALL win.
REQ-010 If a software write to TCON and a TIF-setting overflow happen in the same cycle, TIF SHALL be 1; TEN and TIE SHALL take the written values.
REQ-011 The FSM SHALL have three states: IDLE, PENDING and SERVICE.
REQ-012 IDLE -> PENDING SHALL occur when TIF=1, TIE=1 and PCSupervisor=0.
REQ-013 PENDING -> SERVICE SHALL occur on IrqTaken=1, and ICNT SHALL increment, saturating at 32'hFFFFFFFF.
REQ-014 PENDING -> IDLE SHALL occur when TIF=0 or TIE=0 and IrqTaken=0.
REQ-015 SERVICE -> IDLE SHALL occur on the first cycle with PCSupervisor=0, i.e. the handler has exited.
REQ-016 IRQ SHALL be a registered decode: 1 only in PENDING, and it SHALL fall on the edge that enters SERVICE.
REQ-017 An overflow during SERVICE SHALL set TIF but SHALL NOT assert IRQ until the FSM has returned to IDLE and REQ-012 holds again (minimum one IDLE cycle).
REQ-018 IrqTaken outside PENDING SHALL be ignored.

Reset
REQ-019 On reset low, the block SHALL immediately set TH=0, TL=0, TCON=3'b000, ICNT=0, state=IDLE and IRQ=0.
REQ-020 ReadData SHALL be 0 during reset unless MemRd=1 with a matching address.
REQ-021 Reset asserted mid-PENDING or mid-SERVICE SHALL abandon the request with no residual IRQ.

Structure
REQ-022 The address constants, the TCON bit indices and the FSM state encoding SHALL live in a shared package, irq_timer_pkg.
REQ-023 The TH/TL counter and overflow-pulse logic SHALL be one sub-module, timer_core; the bus decode, TCON, ICNT and FSM SHALL stay in irq_timer_ctrl.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
  - TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3'b011 -> overflow two cycles later; TL=32'hFFFFFFFC; TIF=1; IRQ=1 one cycle after TIF.
  - IRQ=1, then IrqTaken pulse -> IRQ=0 next edge; ICNT=1; state SERVICE; IRQ stays 0 while PCSupervisor=1 despite a second overflow; PCSupervisor=0 -> IDLE, then IRQ=1 again.
  - TCON write of 3'b011 in the same cycle as an overflow -> read TCON=3'b111.
  - TL write of 32'h10 in the same cycle as an overflow -> TL=32'h10, not TH.
  - TCON=3'b001 (TIE=0) with overflow -> TIF=0, IRQ never set; read 0x40000010 -> ReadData=0.
  - reset pulled low while PENDING -> IRQ=0 asynchronously; all registers read 0 after release.
